// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Turns the raw, asynchronous PLL lock flag into a clean system reset for the
// PLL clock domain. Reset is released only once lock has been stable for
// LOCK_CYCLES cycles, followed by a further HOLD_CYCLES cycles of hold. Reset
// is re-asserted whenever lock drops. Lock losses seen while running are
// recorded in a sticky flag and a saturating counter for host diagnostics.
//
// Ports:
//   clock_in     - PLL output clock, the only clock
//   reset_n      - async active-low reset (deassertion synchronised upstream)
//   locked       - raw PLL lock indicator, asynchronous to clock_in
//   clear_flags  - one-cycle pulse, clears lock_lost and loss_count
//   sys_reset_n  - registered active-low system reset
//   ready        - registered, high exactly when sys_reset_n is high
//   lock_lost    - sticky: lock was lost while in RUN
//   loss_count   - saturating count of RUN-state lock losses
//   state        - current FSM state
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_LOCK | reset held, waiting for synchronised lock
// STABILIZE | lock seen, counting LOCK_CYCLES consecutive locked cycles
// HOLD      | lock qualified, holding reset HOLD_CYCLES more cycles
// RUN       | reset released; any lock drop here is a recorded loss event

module pll_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 locked,
    input  logic                 clear_flags,
    output logic                 sys_reset_n,
    output logic                 ready,
    output logic                 lock_lost,
    output logic [CNT_WIDTH-1:0] loss_count,
    output logic [1:0]           state
);

    localparam int CNT_MAX = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // The phase timer counts down from its load value; reaching zero marks
    // the last cycle of the phase.
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   locked_s;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   sys_reset_n_q, sys_reset_n_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [CNT_WIDTH-1:0]   loss_count_q, loss_count_d;
    logic                   loss_event;

    // Lock synchroniser
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], locked};
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // State register (plus phase timer and registered outputs)
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            sys_reset_n_q <= 1'b0;
            lock_lost_q   <= 1'b0;
            loss_count_q  <= '0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sys_reset_n_q <= sys_reset_n_d;
            lock_lost_q   <= lock_lost_d;
            loss_count_q  <= loss_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = LOCK_LOAD;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: everything is registered from next-state values, so the
    // reset releases on the very edge that enters RUN and asserts on the edge
    // that leaves it.
    always_comb begin
        loss_event    = (state_q == RUN) && !locked_s;
        sys_reset_n_d = (state_d == RUN);
        lock_lost_d   = lock_lost_q;
        loss_count_d  = loss_count_q;
        if (loss_event) begin
            // A loss coinciding with a clear still gets recorded, as the
            // first event after the clear.
            lock_lost_d = 1'b1;
            if (clear_flags) begin
                loss_count_d = CNT_WIDTH'(1);
            end else if (loss_count_q != '1) begin
                loss_count_d = loss_count_q + 1'b1;
            end
        end else if (clear_flags) begin
            lock_lost_d  = 1'b0;
            loss_count_d = '0;
        end
    end

    assign sys_reset_n = sys_reset_n_q;
    assign ready       = sys_reset_n_q;
    assign lock_lost   = lock_lost_q;
    assign loss_count  = loss_count_q;
    assign state       = state_q;

endmodule
